// File: rtl/randomizer_frame_ctrl.sv
// Frame sequencer around a 2-bit/step Gold-sequence randomizer core: seeds the core at
// each frame start, passes the header clear and scrambles the payload with valid/ready flow.
//
// state | meaning
// IDLE  | waiting for i_start; symbol counter held at zero
// SEED  | one cycle, o_rnd_reset high so the core restarts from its seed
// HDR   | leading HDR_LEN symbols passed unscrambled
// DATA  | payload symbols XORed with the core output (or passed if bypass latched)
module randomizer_frame_ctrl #(
  parameter int FRAME_LEN = 1024,
  parameter int HDR_LEN   = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_bypass,
  input  logic [1:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic [1:0] o_m_data,
  output logic       o_m_valid,
  input  logic       i_m_ready,
  output logic       o_m_last,
  output logic       o_busy,
  output logic       o_rnd_reset,
  output logic       o_rnd_en,
  input  logic [1:0] i_rnd
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_HDR,
    ST_DATA
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [15:0] HDR_LAST = 16'((HDR_LEN > 0) ? HDR_LEN - 1 : 0);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        bypass_q;
  logic        accept;

  assign o_s_ready = ((state == ST_HDR) || (state == ST_DATA)) && (!o_m_valid || i_m_ready);
  assign accept    = i_s_valid && o_s_ready;
  // The core only steps when a scrambled payload symbol actually moves, so stalls lose nothing.
  assign o_rnd_en  = accept && (state == ST_DATA) && !bypass_q;
  assign o_busy    = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_start) state_nxt = ST_SEED;
      ST_SEED: state_nxt = (HDR_LEN > 0) ? ST_HDR : ST_DATA;
      ST_HDR:  if (accept && (cnt == HDR_LAST)) state_nxt = ST_DATA;
      ST_DATA: if (accept && (cnt == LAST_IDX)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt         <= '0;
      bypass_q    <= 1'b0;
      o_rnd_reset <= 1'b1;
    end else begin
      // High exactly during the SEED cycle that follows a start in IDLE.
      o_rnd_reset <= (state == ST_IDLE) && i_start;
      if (state == ST_IDLE) begin
        cnt <= '0;
        if (i_start) bypass_q <= i_bypass;
      end else if (accept) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_m_valid <= 1'b0;
      o_m_data  <= 2'b00;
      o_m_last  <= 1'b0;
    end else if (accept) begin
      o_m_valid <= 1'b1;
      o_m_data  <= ((state == ST_HDR) || bypass_q) ? i_s_data : (i_s_data ^ i_rnd);
      o_m_last  <= (cnt == LAST_IDX);
    end else if (i_m_ready) begin
      o_m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_randomizer_frame_ctrl.sv
// Bench for randomizer_frame_ctrl: two instances (FRAME_LEN=4/HDR_LEN=0 and 10/2), each
// with a table-driven stand-in randomizer core, checked against a symbol-level model.
module tb_randomizer_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      start, bypass, s_valid, m_ready;
  logic [1:0]      s_ready, m_valid, m_last, busy, rnd_reset, rnd_en;
  logic [1:0][1:0] s_data, m_data, rnd;
  logic [1:0]      seq [64];

  int checks = 0;
  int errors = 0;

  logic [1:0] got_data [$];
  logic       got_last [$];
  logic       got_en   [$];
  logic       timed_out;
  logic [1:0] t1_out   [$];

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [5:0] idx;
    int         rr_cnt = 0;

    randomizer_frame_ctrl #(
      .FRAME_LEN(g == 0 ? 4 : 10),
      .HDR_LEN  (g == 0 ? 0 : 2)
    ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_start    (start[g]),
      .i_bypass   (bypass[g]),
      .i_s_data   (s_data[g]),
      .i_s_valid  (s_valid[g]),
      .o_s_ready  (s_ready[g]),
      .o_m_data   (m_data[g]),
      .o_m_valid  (m_valid[g]),
      .i_m_ready  (m_ready[g]),
      .o_m_last   (m_last[g]),
      .o_busy     (busy[g]),
      .o_rnd_reset(rnd_reset[g]),
      .o_rnd_en   (rnd_en[g]),
      .i_rnd      (rnd[g])
    );

    // Stand-in core: async reset to the seed, output is seq[] indexed by step count.
    always_ff @(posedge clk or posedge rnd_reset[g]) begin
      if (rnd_reset[g]) idx <= '0;
      else if (rnd_en[g]) idx <= idx + 6'd1;
    end
    assign rnd[g] = seq[idx];

    always @(negedge clk) if (rnd_reset[g]) rr_cnt <= rr_cnt + 1;
  end

  function automatic int fl_of(int g);
    return (g == 0) ? 4 : 10;
  endfunction

  function automatic int hl_of(int g);
    return (g == 0) ? 0 : 2;
  endfunction

  function automatic int rr_of(int g);
    return (g == 0) ? gi[0].rr_cnt : gi[1].rr_cnt;
  endfunction

  // Reference: symbol i of a frame is clear in the header or under bypass, otherwise
  // XORed with the core's (i - HDR_LEN)-th output counted from the seed.
  function automatic logic [1:0] model_sym(int g, int i, logic byp, logic [1:0] d);
    if (byp || i < hl_of(g)) return d;
    return d ^ seq[i - hl_of(g)];
  endfunction

  task automatic run_frame(input int g, input logic byp, input int stall_pct,
                           input logic [1:0] din [$]);
    int fl, n_in, n_out, cyc;
    fl = fl_of(g);
    got_data.delete(); got_last.delete(); got_en.delete();
    @(posedge clk); #1;
    start[g] = 1'b1; bypass[g] = byp;
    @(posedge clk); #1;
    start[g] = 1'b0; bypass[g] = 1'($urandom);
    n_in = 0; n_out = 0; cyc = 0;
    while ((n_in < fl || n_out < fl) && cyc < 500) begin
      s_valid[g] = (n_in < fl) && ($urandom_range(0, 99) >= stall_pct);
      s_data[g]  = (n_in < fl) ? din[n_in] : 2'($urandom);
      m_ready[g] = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      if (s_valid[g] && s_ready[g]) begin
        got_en.push_back(rnd_en[g]);
        n_in++;
      end
      if (m_valid[g] && m_ready[g]) begin
        got_data.push_back(m_data[g]);
        got_last.push_back(m_last[g]);
        n_out++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid[g] = 1'b0;
    m_ready[g] = 1'b1;
    timed_out = (cyc >= 500);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++; if (m_valid[g] !== 1'b0) begin errors++; $display("FAIL reset_m_valid[%0d] got %b exp 0", g, m_valid[g]); end
      checks++; if (m_data[g] !== 2'b00) begin errors++; $display("FAIL reset_m_data[%0d] got %b exp 00", g, m_data[g]); end
      checks++; if (m_last[g] !== 1'b0) begin errors++; $display("FAIL reset_m_last[%0d] got %b exp 0", g, m_last[g]); end
      checks++; if (busy[g] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", g, busy[g]); end
      checks++; if (s_ready[g] !== 1'b0) begin errors++; $display("FAIL reset_s_ready[%0d] got %b exp 0", g, s_ready[g]); end
      checks++; if (rnd_reset[g] !== 1'b1) begin errors++; $display("FAIL reset_rnd_reset[%0d] got %b exp 1", g, rnd_reset[g]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++; if (rnd_reset[g] !== 1'b0) begin errors++; $display("FAIL idle_rnd_reset[%0d] got %b exp 0", g, rnd_reset[g]); end
    end
  endtask

  task automatic test_no_header;
    logic [1:0] din [$];
    int rr0, n_en;
    for (int i = 0; i < 4; i++) din.push_back(2'b00);
    rr0 = rr_of(0);
    run_frame(0, 1'b0, 0, din);
    checks++; if (timed_out) begin errors++; $display("FAIL nohdr_timeout got %0d outputs exp 4", got_data.size()); end
    checks++; if (got_data[0] !== 2'b00) begin errors++; $display("FAIL nohdr_first got %b exp 00", got_data[0]); end
    checks++; if (got_data[1] !== 2'b01) begin errors++; $display("FAIL nohdr_second got %b exp 01", got_data[1]); end
    n_en = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== model_sym(0, i, 1'b0, din[i])) begin errors++; $display("FAIL nohdr_data[%0d] got %b exp %b", i, got_data[i], model_sym(0, i, 1'b0, din[i])); end
      checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL nohdr_last[%0d] got %b exp %b", i, got_last[i], (i == 3)); end
      if (got_en[i] === 1'b1) n_en++;
    end
    checks++; if (n_en != 4) begin errors++; $display("FAIL nohdr_en_count got %0d exp 4", n_en); end
    checks++; if (rr_of(0) - rr0 != 1) begin errors++; $display("FAIL nohdr_seed_pulses got %0d exp 1", rr_of(0) - rr0); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL nohdr_busy_after got %b exp 0", busy[0]); end
    t1_out = got_data;
  endtask

  task automatic test_header;
    logic [1:0] din [$];
    logic [1:0] exp4 [4];
    exp4 = '{2'b11, 2'b10, 2'b00, 2'b01};
    din.push_back(2'b11); din.push_back(2'b10); din.push_back(2'b00); din.push_back(2'b00);
    for (int i = 4; i < 10; i++) din.push_back(2'($urandom));
    run_frame(1, 1'b0, 0, din);
    checks++; if (timed_out) begin errors++; $display("FAIL hdr_timeout got %0d outputs exp 10", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== exp4[i]) begin errors++; $display("FAIL hdr_fixed[%0d] got %b exp %b", i, got_data[i], exp4[i]); end
    end
    for (int i = 0; i < 10; i++) begin
      checks++; if (got_data[i] !== model_sym(1, i, 1'b0, din[i])) begin errors++; $display("FAIL hdr_data[%0d] got %b exp %b", i, got_data[i], model_sym(1, i, 1'b0, din[i])); end
      checks++; if (got_en[i] !== (i >= 2)) begin errors++; $display("FAIL hdr_rnd_en[%0d] got %b exp %b", i, got_en[i], (i >= 2)); end
      checks++; if (got_last[i] !== (i == 9)) begin errors++; $display("FAIL hdr_last[%0d] got %b exp %b", i, got_last[i], (i == 9)); end
    end
  endtask

  task automatic test_stall;
    logic [1:0] din [$];
    logic [1:0] ref_out [$];
    int n_en;
    for (int i = 0; i < 10; i++) din.push_back(2'($urandom));
    run_frame(1, 1'b0, 0, din);
    ref_out = got_data;
    run_frame(1, 1'b0, 50, din);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout got %0d outputs exp 10", got_data.size()); end
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (got_data[i] !== ref_out[i]) begin errors++; $display("FAIL stall_vs_nostall[%0d] got %b exp %b", i, got_data[i], ref_out[i]); end
      checks++; if (got_data[i] !== model_sym(1, i, 1'b0, din[i])) begin errors++; $display("FAIL stall_data[%0d] got %b exp %b", i, got_data[i], model_sym(1, i, 1'b0, din[i])); end
      if (got_en[i] === 1'b1) n_en++;
    end
    checks++; if (n_en != 8) begin errors++; $display("FAIL stall_en_count got %0d exp 8", n_en); end
  endtask

  task automatic test_back_to_back;
    int rr0, n_in, n_out, cyc;
    rr0 = rr_of(0);
    got_data.delete(); got_last.delete();
    @(posedge clk); #1;
    start[0] = 1'b1; bypass[0] = 1'b0;
    n_in = 0; n_out = 0; cyc = 0;
    // start stays high through frame 1 so the IDLE cycle after its last input launches frame 2
    while (n_out < 8 && cyc < 300) begin
      s_valid[0] = (n_in < 8);
      s_data[0]  = 2'b00;
      m_ready[0] = ($urandom_range(0, 99) >= 40);
      @(negedge clk);
      if (s_valid[0] && s_ready[0]) n_in++;
      if (m_valid[0] && m_ready[0]) begin
        got_data.push_back(m_data[0]);
        got_last.push_back(m_last[0]);
        n_out++;
      end
      @(posedge clk); #1;
      if (rr_of(0) - rr0 >= 2) start[0] = 1'b0;
      cyc++;
    end
    start[0] = 1'b0; s_valid[0] = 1'b0; m_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cyc >= 300) begin errors++; $display("FAIL b2b_timeout got %0d outputs exp 8", n_out); end
    checks++; if (rr_of(0) - rr0 != 2) begin errors++; $display("FAIL b2b_seed_pulses got %0d exp 2", rr_of(0) - rr0); end
    checks++; if (got_data[4] !== 2'b00) begin errors++; $display("FAIL b2b_frame2_first got %b exp 00", got_data[4]); end
    checks++; if (got_data[5] !== 2'b01) begin errors++; $display("FAIL b2b_frame2_second got %b exp 01", got_data[5]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_data[i] !== model_sym(0, i % 4, 1'b0, 2'b00)) begin errors++; $display("FAIL b2b_data[%0d] got %b exp %b", i, got_data[i], model_sym(0, i % 4, 1'b0, 2'b00)); end
      checks++; if (got_last[i] !== ((i % 4) == 3)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", i, got_last[i], ((i % 4) == 3)); end
    end
  endtask

  task automatic test_bypass;
    logic [1:0] din [$];
    int n_en;
    for (int i = 0; i < 10; i++) din.push_back(2'($urandom));
    run_frame(1, 1'b1, 30, din);
    checks++; if (timed_out) begin errors++; $display("FAIL byp_timeout got %0d outputs exp 10", got_data.size()); end
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (got_data[i] !== din[i]) begin errors++; $display("FAIL byp_data[%0d] got %b exp %b", i, got_data[i], din[i]); end
      if (got_en[i] !== 1'b0) n_en++;
    end
    checks++; if (n_en != 0) begin errors++; $display("FAIL byp_rnd_en got %0d pulses exp 0", n_en); end
  endtask

  task automatic test_reset_mid_frame;
    logic [1:0] din [$];
    logic seen;
    @(posedge clk); #1;
    start[0] = 1'b1; bypass[0] = 1'b0; m_ready[0] = 1'b0;
    s_valid[0] = 1'b1; s_data[0] = 2'b01;
    @(posedge clk); #1;
    start[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_valid[0]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (!seen) begin errors++; $display("FAIL midrst_pending got %b exp 1", seen); end
    checks++; if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL midrst_m_valid got %b exp 0", m_valid[0]); end
    checks++; if (rnd_reset[0] !== 1'b1) begin errors++; $display("FAIL midrst_rnd_reset got %b exp 1", rnd_reset[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy[0]); end
    @(posedge clk); #1;
    rst = 1'b0; s_valid[0] = 1'b0; m_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) din.push_back(2'b00);
    run_frame(0, 1'b0, 0, din);
    checks++; if (timed_out) begin errors++; $display("FAIL midrst_timeout got %0d outputs exp 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== t1_out[i]) begin errors++; $display("FAIL midrst_repeat[%0d] got %b exp %b", i, got_data[i], t1_out[i]); end
    end
  endtask

  initial begin
    seq[0] = 2'b00;
    seq[1] = 2'b01;
    for (int i = 2; i < 64; i++) seq[i] = 2'($urandom);
    rst = 1'b1;
    start = '0; bypass = '0; s_valid = '0; m_ready = 2'b11;
    s_data = '0;
    test_reset();
    test_no_header();
    test_header();
    test_stall();
    test_back_to_back();
    test_bypass();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
